// File: rtl/multi_channel_system_timer_pkg.sv
// Shared types and register map for the multi-channel machine timer.
// Latency: none (types and constants only).
// Backpressure: none; the peripheral bus is single-cycle and always ready.
package multi_channel_system_timer_pkg;

  localparam int MST_ADDR_W = 8;

  // Global word offsets
  localparam logic [MST_ADDR_W-1:0] MST_MTIME_L = 8'd0;
  localparam logic [MST_ADDR_W-1:0] MST_MTIME_H = 8'd1;
  localparam logic [MST_ADDR_W-1:0] MST_CTRL    = 8'd2;
  localparam logic [MST_ADDR_W-1:0] MST_STATUS  = 8'd3;

  // Channel k occupies words MST_CH_BASE + 4k .. +3
  localparam int         MST_CH_BASE   = 4;
  localparam logic [1:0] MST_CH_CMP_L  = 2'd0;
  localparam logic [1:0] MST_CH_CMP_H  = 2'd1;
  localparam logic [1:0] MST_CH_PERIOD = 2'd2;
  localparam logic [1:0] MST_CH_CTRL   = 2'd3;

  localparam logic [63:0] MST_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [MST_ADDR_W-1:0] raddr;
    logic [MST_ADDR_W-1:0] waddr;
    logic [31:0]           wdata;
  } sys_peripheral_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  // CTRL word layout: [0] enable, [8+:prescale width] prescale
  typedef struct packed {
    logic [23:0] prescale;
    logic [6:0]  rsvd;
    logic        en;
  } mst_ctrl_t;

  // CHCTRL word layout: [0] en, [1] periodic, [2] inten
  typedef struct packed {
    logic [28:0] rsvd;
    logic        inten;
    logic        periodic;
    logic        en;
  } mst_chctrl_t;

  // Address bits [7:2] that select channel k's 4-word block
  function automatic logic [MST_ADDR_W-3:0] mst_ch_block(input int k);
    return (MST_ADDR_W-2)'(MST_CH_BASE / 4 + k);
  endfunction

endpackage

// File: rtl/multi_channel_system_timer_if.sv
// System-peripheral bus bundle: shared address/data, per-slave selects, read data.
// Latency: read data is registered one cycle after the read select.
// Backpressure: none; every access completes in one cycle.
interface multi_channel_system_timer_if;
  import multi_channel_system_timer_pkg::*;

  sys_peripheral_t sys_share;
  sel_t            sel;
  logic [31:0]     rdata;

  modport master (output sys_share, output sel, input rdata);
  modport slave  (input sys_share, input sel, output rdata);
endinterface

// File: rtl/mst_cmp_channel.sv
// One compare channel: cmp/period/chctrl registers, hit, periodic advance, pending, irq.
// Latency: pending 1 cycle after mtime/cmp change, irq 1 cycle after pending.
// Backpressure: none; register writes always accepted.
module mst_cmp_channel
  import multi_channel_system_timer_pkg::*;
(
  input  logic        hb_clk,
  input  logic        rst,
  input  logic [63:0] mtime,
  input  logic [3:0]  wr,       // one-hot by word: CMP_L, CMP_H, PERIOD, CHCTRL
  input  logic [31:0] wdata,
  input  logic        clr,      // STATUS write-1-to-clear for this channel
  output logic [63:0] cmp,
  output logic [31:0] period,
  output mst_chctrl_t chctrl,
  output logic        pending,
  output logic        irq
);

  logic        hit;
  logic        advance;
  logic        cmp_wr;
  logic [63:0] cmp_next;

  assign hit      = chctrl.en & (mtime >= cmp);
  assign advance  = hit & chctrl.periodic & (period != 32'd0);
  assign cmp_wr   = wr[MST_CH_CMP_L] | wr[MST_CH_CMP_H];
  assign cmp_next = cmp + {32'd0, period};

  // Compare value: CPU write wins over the periodic advance; one advance per cycle
  always_ff @(posedge hb_clk) begin
    if (rst) begin
      cmp <= MST_CMP_RESET;
    end else if (wr[MST_CH_CMP_L]) begin
      cmp[31:0] <= wdata;
    end else if (wr[MST_CH_CMP_H]) begin
      cmp[63:32] <= wdata;
    end else if (advance) begin
      cmp <= cmp_next;
    end
  end

  // Period and channel control registers
  always_ff @(posedge hb_clk) begin
    if (rst) begin
      period <= 32'd0;
      chctrl <= '0;
    end else begin
      if (wr[MST_CH_PERIOD]) period <= wdata;
      if (wr[MST_CH_CTRL])   chctrl <= '{rsvd: '0, inten: wdata[2], periodic: wdata[1], en: wdata[0]};
    end
  end

  // Pending: CMP write clears and dominates, then a hit sets, then W1C clears
  always_ff @(posedge hb_clk) begin
    if (rst)         pending <= 1'b0;
    else if (cmp_wr) pending <= 1'b0;
    else if (hit)    pending <= 1'b1;
    else if (clr)    pending <= 1'b0;
  end

  // Level interrupt, registered from pending
  always_ff @(posedge hb_clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= pending & chctrl.inten;
  end

endmodule

// File: rtl/multi_channel_system_timer.sv
// 64-bit machine timer with tick prescaler and NUM_CMP compare channels.
// Latency: mtime edge -> irq 2 cycles; read data 1 cycle after ren.
// Backpressure: none; bus accesses always complete in one cycle.
module multi_channel_system_timer
  import multi_channel_system_timer_pkg::*;
#(
  parameter int NUM_CMP    = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                       hb_clk,
  input  logic                       rst,
  input  logic                       tick_src,
  multi_channel_system_timer_if.slave bus,
  output logic [NUM_CMP-1:0]         irq,
  output logic                       mtimer_int
);

  logic                  tick_q;
  logic                  tick;
  logic                  inc;
  logic [PRESCALE_W-1:0] cnt;
  logic [63:0]           mtime;
  mst_ctrl_t             ctrl;

  logic                  wen;
  logic [MST_ADDR_W-1:0] waddr;
  logic [MST_ADDR_W-1:0] raddr;
  logic [31:0]           wdata;
  logic                  wr_mtime_l, wr_mtime_h, wr_ctrl, wr_status;

  logic [63:0]           ch_cmp    [NUM_CMP];
  logic [31:0]           ch_period [NUM_CMP];
  mst_chctrl_t           ch_ctrl   [NUM_CMP];
  logic [NUM_CMP-1:0]    pending;
  logic [31:0]           rd_val;

  assign wen   = bus.sel.wen;
  assign waddr = bus.sys_share.waddr;
  assign raddr = bus.sys_share.raddr;
  assign wdata = bus.sys_share.wdata;

  assign wr_mtime_l = wen & (waddr == MST_MTIME_L);
  assign wr_mtime_h = wen & (waddr == MST_MTIME_H);
  assign wr_ctrl    = wen & (waddr == MST_CTRL);
  assign wr_status  = wen & (waddr == MST_STATUS);

  // tick_src is a slow data input; its rising edge is one prescaler step
  assign tick = tick_src & ~tick_q;
  assign inc  = ctrl.en & tick & (cnt == ctrl.prescale[PRESCALE_W-1:0]);

  // Tick edge detect and prescaler; a CTRL write restarts the prescale phase
  always_ff @(posedge hb_clk) begin
    if (rst) begin
      tick_q <= 1'b0;
      cnt    <= '0;
    end else begin
      tick_q <= tick_src;
      if (wr_ctrl)               cnt <= '0;
      else if (ctrl.en && tick)  cnt <= inc ? '0 : cnt + 1'b1;
    end
  end

  // Timer control register
  always_ff @(posedge hb_clk) begin
    if (rst)          ctrl <= '0;
    else if (wr_ctrl) ctrl <= '{prescale: 24'(wdata[8 +: PRESCALE_W]), rsvd: '0, en: wdata[0]};
  end

  // mtime: a CPU write to either half drops that cycle's increment
  always_ff @(posedge hb_clk) begin
    if (rst)             mtime <= 64'd0;
    else if (wr_mtime_l) mtime[31:0]  <= wdata;
    else if (wr_mtime_h) mtime[63:32] <= wdata;
    else if (inc)        mtime <= mtime + 64'd1;
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_ch
    logic       ch_wsel;
    logic [3:0] ch_wr;

    assign ch_wsel = wen & (waddr[MST_ADDR_W-1:2] == mst_ch_block(k));
    assign ch_wr   = ch_wsel ? (4'b0001 << waddr[1:0]) : 4'b0000;

    mst_cmp_channel u_ch (
      .hb_clk  (hb_clk),
      .rst     (rst),
      .mtime   (mtime),
      .wr      (ch_wr),
      .wdata   (wdata),
      .clr     (wr_status & wdata[k]),
      .cmp     (ch_cmp[k]),
      .period  (ch_period[k]),
      .chctrl  (ch_ctrl[k]),
      .pending (pending[k]),
      .irq     (irq[k])
    );
  end

  assign mtimer_int = irq[0];

  // Read mux; anything not decoded reads as zero
  always_comb begin
    rd_val = 32'd0;
    case (raddr)
      MST_MTIME_L: rd_val = mtime[31:0];
      MST_MTIME_H: rd_val = mtime[63:32];
      MST_CTRL:    rd_val = ctrl;
      MST_STATUS:  rd_val = 32'(pending);
      default:     rd_val = 32'd0;
    endcase
    for (int k = 0; k < NUM_CMP; k++) begin
      if (raddr[MST_ADDR_W-1:2] == mst_ch_block(k)) begin
        case (raddr[1:0])
          MST_CH_CMP_L:  rd_val = ch_cmp[k][31:0];
          MST_CH_CMP_H:  rd_val = ch_cmp[k][63:32];
          MST_CH_PERIOD: rd_val = ch_period[k];
          default:       rd_val = ch_ctrl[k];
        endcase
      end
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge hb_clk) begin
    if (rst)              bus.rdata <= 32'd0;
    else if (bus.sel.ren) bus.rdata <= rd_val;
  end

endmodule

// File: tb/tb_multi_channel_system_timer.sv
// Self-checking bench for multi_channel_system_timer.
// Latency: reads complete one cycle after ren; irq checked cycle-by-cycle.
// Backpressure: none; bus is always ready.
module tb_multi_channel_system_timer;
  import multi_channel_system_timer_pkg::*;

  localparam int NUM_CMP = 4;

  logic               hb_clk = 1'b0;
  logic               rst;
  logic               tick_src;
  logic [NUM_CMP-1:0] irq;
  logic               mtimer_int;

  multi_channel_system_timer_if bus ();

  multi_channel_system_timer #(.NUM_CMP(NUM_CMP), .PRESCALE_W(8)) dut (
    .hb_clk     (hb_clk),
    .rst        (rst),
    .tick_src   (tick_src),
    .bus        (bus),
    .irq        (irq),
    .mtimer_int (mtimer_int)
  );

  always #5 hb_clk = ~hb_clk;

  int          checks   = 0;
  int          failures = 0;
  string       nm_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  function automatic logic [7:0] ch_addr(input int k, input int off);
    return 8'(4 + 4 * k + off);
  endfunction

  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.sys_share.waddr = a;
    bus.sys_share.wdata = d;
    bus.sel.wen = 1'b1;
    step();
    bus.sel.wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.sys_share.raddr = a;
    bus.sel.ren = 1'b1;
    step();
    bus.sel.ren = 1'b0;
    d = bus.rdata;
  endtask

  // Expected value is queued when the read is issued; result queued when it returns
  task automatic sb_read(input string nm, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] d;
    nm_q.push_back(nm);
    exp_q.push_back(e);
    bus_read(a, d);
    got_q.push_back(d);
  endtask

  task automatic tick();
    tick_src = 1'b1;
    step();
    tick_src = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    string n; logic [31:0] e, g;
    rst = 1'b1; tick_src = 1'b0;
    bus.sel.wen = 1'b0; bus.sel.ren = 1'b0;
    bus.sys_share.raddr = '0; bus.sys_share.waddr = '0; bus.sys_share.wdata = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
    checks++; if (irq !== 4'd0) begin failures++; $display("FAIL rst_irq got=%b exp=0000", irq); end
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL rst_mtimer_int got=%b exp=0", mtimer_int); end
    sb_read("rst_mtime_l", MST_MTIME_L, 32'd0);
    sb_read("rst_mtime_h", MST_MTIME_H, 32'd0);
    sb_read("rst_ctrl", MST_CTRL, 32'd0);
    sb_read("rst_status", MST_STATUS, 32'd0);
    sb_read("rst_cmp0_l", ch_addr(0, 0), 32'hFFFF_FFFF);
    sb_read("rst_cmp3_h", ch_addr(3, 1), 32'hFFFF_FFFF);
    sb_read("rst_period1", ch_addr(1, 2), 32'd0);
    sb_read("rst_chctrl2", ch_addr(2, 3), 32'd0);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_prescale();
    string n; logic [31:0] e, g;
    bus_write(MST_CTRL, 32'h0000_0301);
    sb_read("ps_ctrl", MST_CTRL, 32'h0000_0301);
    ticks(8);
    sb_read("ps_8ticks", MST_MTIME_L, 32'd2);
    ticks(3);
    sb_read("ps_11ticks", MST_MTIME_L, 32'd2);
    ticks(1);
    sb_read("ps_12ticks", MST_MTIME_L, 32'd3);
    sb_read("ps_mtime_h", MST_MTIME_H, 32'd0);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_carry();
    string n; logic [31:0] e, g;
    bus_write(MST_CTRL, 32'h0000_0001);
    bus_write(MST_MTIME_H, 32'd0);
    bus_write(MST_MTIME_L, 32'hFFFF_FFFF);
    tick();
    sb_read("carry_h", MST_MTIME_H, 32'd1);
    sb_read("carry_l", MST_MTIME_L, 32'd0);
    // Tick edge and MTIME_L write land on the same clock edge
    tick_src = 1'b1;
    bus_write(MST_MTIME_L, 32'h0000_1234);
    tick_src = 1'b0;
    step();
    sb_read("wr_wins_l", MST_MTIME_L, 32'h0000_1234);
    sb_read("wr_wins_h", MST_MTIME_H, 32'd1);
    bus_write(MST_MTIME_H, 32'hFFFF_FFFF);
    bus_write(MST_MTIME_L, 32'hFFFF_FFFF);
    tick();
    sb_read("wrap_l", MST_MTIME_L, 32'd0);
    sb_read("wrap_h", MST_MTIME_H, 32'd0);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_oneshot();
    string n; logic [31:0] e, g;
    bus_write(MST_MTIME_H, 32'd0);
    bus_write(MST_MTIME_L, 32'd8);
    bus_write(ch_addr(0, 0), 32'd10);
    bus_write(ch_addr(0, 1), 32'd0);
    bus_write(ch_addr(0, 3), 32'd5);        // en + inten, one-shot
    tick();                                 // mtime = 9
    step();
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL os_mtime9 got=%b exp=0", mtimer_int); end
    tick_src = 1'b1;
    step();                                 // mtime = 10 on this edge
    tick_src = 1'b0;
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL os_lat0 got=%b exp=0", mtimer_int); end
    step();
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL os_lat1 got=%b exp=0", mtimer_int); end
    step();
    checks++; if (mtimer_int !== 1'b1) begin failures++; $display("FAIL os_lat2 got=%b exp=1", mtimer_int); end
    checks++; if (irq !== 4'b0001) begin failures++; $display("FAIL os_irq_vec got=%b exp=0001", irq); end
    bus_write(ch_addr(0, 0), 32'd20);
    step();
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL os_cmp_wr_clr got=%b exp=0", mtimer_int); end
    ticks(9);                               // mtime = 19
    step();
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL os_mtime19 got=%b exp=0", mtimer_int); end
    tick();                                 // mtime = 20
    step();
    checks++; if (mtimer_int !== 1'b1) begin failures++; $display("FAIL os_mtime20 got=%b exp=1", mtimer_int); end
    sb_read("os_status", MST_STATUS, 32'd1);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_periodic();
    string n; logic [31:0] e, g;
    bus_write(ch_addr(0, 3), 32'd0);
    bus_write(MST_STATUS, 32'd1);
    bus_write(MST_MTIME_H, 32'd0);
    bus_write(MST_MTIME_L, 32'd0);
    bus_write(ch_addr(1, 0), 32'd5);
    bus_write(ch_addr(1, 1), 32'd0);
    bus_write(ch_addr(1, 2), 32'd5);
    bus_write(ch_addr(1, 3), 32'd7);        // en + periodic + inten
    ticks(4);
    sb_read("per_before", MST_STATUS, 32'd0);
    for (int h = 1; h <= 3; h++) begin
      if (h > 1) ticks(4);
      tick();                               // mtime = 5h
      sb_read($sformatf("per_hit%0d", h), MST_STATUS, 32'd2);
      sb_read($sformatf("per_cmp%0d", h), ch_addr(1, 0), 32'(5 * h + 5));
      bus_write(MST_STATUS, 32'd2);
      sb_read($sformatf("per_w1c%0d", h), MST_STATUS, 32'd0);
    end
    ticks(4);                               // mtime = 19
    tick_src = 1'b1;
    step();                                 // mtime = 20
    tick_src = 1'b0;
    bus_write(MST_STATUS, 32'd2);           // W1C on the hit cycle
    sb_read("per_set_wins", MST_STATUS, 32'd2);
    sb_read("per_cmp25", ch_addr(1, 0), 32'd25);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_catch_up();
    string n; logic [31:0] e, g, mdl;
    bus_write(MST_MTIME_H, 32'd0);
    bus_write(MST_MTIME_L, 32'd100);
    bus_write(ch_addr(2, 0), 32'd0);
    bus_write(ch_addr(2, 1), 32'd0);
    bus_write(ch_addr(2, 2), 32'd4);
    bus_write(ch_addr(2, 3), 32'd3);        // en + periodic
    mdl = 32'd0;
    for (int j = 0; j < 30; j++) begin
      sb_read($sformatf("cu_step%0d", j), ch_addr(2, 0), mdl);
      if (mdl <= 32'd100) mdl = mdl + 32'd4;
    end
    sb_read("cu_status", MST_STATUS, 32'h6);
    bus_write(ch_addr(3, 0), 32'd50);
    bus_write(ch_addr(3, 1), 32'd0);
    bus_write(ch_addr(3, 3), 32'd7);        // periodic with PERIOD = 0
    step(); step(); step();
    sb_read("p0_cmp_l", ch_addr(3, 0), 32'd50);
    sb_read("p0_status", MST_STATUS, 32'hE);
    sb_read("cu_cmp_final", ch_addr(2, 0), 32'd104);
    sb_read("cu_cmp_h", ch_addr(2, 1), 32'd0);
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  task automatic test_unmapped_and_reset();
    string n; logic [31:0] e, g, d;
    sb_read("unmapped_3f", 8'h3F, 32'd0);
    sb_read("unmapped_20", 8'd20, 32'd0);
    bus_read(MST_MTIME_L, d);               // leave rdata non-zero
    bus_write(MST_CTRL, 32'h0000_0201);
    tick();
    tick_src = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick_src = 1'b0;
    checks++; if (bus.rdata !== 32'd0) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=0", bus.rdata); end
    checks++; if (irq !== 4'd0) begin failures++; $display("FAIL mid_rst_irq got=%b exp=0000", irq); end
    checks++; if (mtimer_int !== 1'b0) begin failures++; $display("FAIL mid_rst_mtimer got=%b exp=0", mtimer_int); end
    sb_read("mid_rst_mtime_l", MST_MTIME_L, 32'd0);
    sb_read("mid_rst_ctrl", MST_CTRL, 32'd0);
    sb_read("mid_rst_status", MST_STATUS, 32'd0);
    sb_read("mid_rst_cmp2_l", ch_addr(2, 0), 32'hFFFF_FFFF);
    sb_read("mid_rst_cmp1_h", ch_addr(1, 1), 32'hFFFF_FFFF);
    sb_read("mid_rst_period2", ch_addr(2, 2), 32'd0);
    sb_read("mid_rst_chctrl3", ch_addr(3, 3), 32'd0);
    ticks(3);
    sb_read("post_rst_stopped", MST_MTIME_L, 32'd0);
    checks++; if (irq !== 4'd0) begin failures++; $display("FAIL post_rst_irq got=%b exp=0000", irq); end
    while (exp_q.size() > 0) begin
      n = nm_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s got=%h exp=%h", n, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_oneshot();
    test_periodic();
    test_catch_up();
    test_unmapped_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
